divider_n: RTL and testbench

DIVIDER_N -- requirements
Module: divider_n

---
 rtl/divider_pkg.sv | 16 +
 rtl/divider_n_sub.sv | 20 ++
 rtl/divider_n.sv | 181 ++++++++++++++++++
 tb/tb_divider_n.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the divider_n block.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Widest supported operand; quotient patterns are sliced down from this.
  localparam int unsigned MAX_N = 64;

  // Quotient reported for a zero divisor (all ones at any width).
  localparam logic [MAX_N-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/divider_n_sub.sv
// sub_n: W-bit trial subtraction a - b with borrow-out (unsigned).
module sub_n #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] difference,
  output logic         borrow
);

  logic [W:0] full;

  // One extra bit captures the borrow of the unsigned subtraction.
  always_comb begin
    full       = {1'b0, a} - {1'b0, b};
    difference = full[W-1:0];
    borrow     = full[W];
  end

endmodule

// File: rtl/divider_n.sv
// divider_n: iterative restoring divider, one quotient bit per cycle.
// Optional macro DIVIDER_SIGNED_EN adds an is_signed input for
// two's-complement operation (magnitude division with sign fix-up).
module divider_n #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
`ifdef DIVIDER_SIGNED_EN
  input  logic         is_signed,
`endif
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  import divider_pkg::*;

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned W  = N + 1;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [N-1:0]   part, part_nxt;
  logic [N-1:0]   quo, quo_nxt;
  logic [N-1:0]   dsr, dsr_nxt;
  logic           busy_nxt, done_nxt, dbz_nxt;
  logic [N-1:0]   quotient_nxt, remainder_nxt;

  logic [N-1:0]   a_mag, b_mag;
  logic [N-1:0]   step_part, step_quo;
  logic [N-1:0]   fin_q, fin_r;

  logic [W-1:0]   trial_a, trial_b, diff;
  logic           borrow;
  logic           unused_diff_msb;

`ifdef DIVIDER_SIGNED_EN
  logic           q_neg, q_neg_nxt;
  logic           r_neg, r_neg_nxt;
  logic           a_neg, b_neg;
`endif

  // Trial subtraction of the divisor from the shifted partial remainder.
  assign trial_a = {part, quo[N-1]};
  assign trial_b = {1'b0, dsr};

  sub_n #(.W(W)) u_sub (
    .a          (trial_a),
    .b          (trial_b),
    .difference (diff),
    .borrow     (borrow)
  );

  // A kept difference is always below the divisor, so its MSB is zero.
  assign unused_diff_msb = diff[N];

  // Restoring step: keep the difference unless the subtraction borrowed.
  always_comb begin
    step_part = borrow ? trial_a[N-1:0] : diff[N-1:0];
    step_quo  = {quo[N-2:0], ~borrow};
  end

`ifdef DIVIDER_SIGNED_EN
  // Operand magnitudes and result sign fix-up for two's-complement mode.
  always_comb begin
    a_neg = is_signed & dividend[N-1];
    b_neg = is_signed & divisor[N-1];
    a_mag = a_neg ? (~dividend + N'(1)) : dividend;
    b_mag = b_neg ? (~divisor + N'(1)) : divisor;
    fin_q = q_neg ? (~step_quo + N'(1)) : step_quo;
    fin_r = r_neg ? (~step_part + N'(1)) : step_part;
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
    fin_q = step_quo;
    fin_r = step_part;
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    part_nxt      = part;
    quo_nxt       = quo;
    dsr_nxt       = dsr;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;
    dbz_nxt       = div_by_zero;
`ifdef DIVIDER_SIGNED_EN
    q_neg_nxt     = q_neg;
    r_neg_nxt     = r_neg;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_nxt  = N'(DBZ_QUOTIENT);
            remainder_nxt = dividend;
            dbz_nxt       = 1'b1;
            state_nxt     = FINISH;
          end else begin
            part_nxt  = '0;
            quo_nxt   = a_mag;
            dsr_nxt   = b_mag;
            cnt_nxt   = CW'(N);
`ifdef DIVIDER_SIGNED_EN
            q_neg_nxt = a_neg ^ b_neg;
            r_neg_nxt = a_neg;
`endif
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        part_nxt = step_part;
        quo_nxt  = step_quo;
        cnt_nxt  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          quotient_nxt  = fin_q;
          remainder_nxt = fin_r;
          dbz_nxt       = 1'b0;
          state_nxt     = FINISH;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == FINISH);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      part        <= '0;
      quo         <= '0;
      dsr         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      part        <= part_nxt;
      quo         <= quo_nxt;
      dsr         <= dsr_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      div_by_zero <= dbz_nxt;
`ifdef DIVIDER_SIGNED_EN
      q_neg       <= q_neg_nxt;
      r_neg       <= r_neg_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_divider_n.sv
// Scoreboard bench for divider_n at N=8: a driver pushes expected results,
// a monitor pops and compares them whenever done is seen.
module tb_divider_n;

  localparam int unsigned N = 8;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
`ifdef DIVIDER_SIGNED_EN
  logic         sg_drv;
`endif

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  divider_n #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef DIVIDER_SIGNED_EN
    .is_signed   (sg_drv),
`endif
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: plain arithmetic on integers.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sg);
    exp_t e;
    int   sa, sb;
    e.cyc = 0;
    if (b == 0) begin
      e.q = {N{1'b1}};
      e.r = a;
      e.dbz = 1'b1;
    end else if (!sg) begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end else begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -(2 ** (N - 1)) && sb == -1) begin
        e.q = N'(sa);
        e.r = '0;
      end else begin
        e.q = N'(sa / sb);
        e.r = N'(sa % sb);
      end
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Issue one division, push its expected result, and wait for completion.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic sg, input bit noise);
    exp_t e;
    bit   got;
    int   guard;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("idle_timeout", 64'(busy), 64'd0);
    start = 1'b1;
    dividend = a;
    divisor = b;
`ifdef DIVIDER_SIGNED_EN
    sg_drv = sg;
`endif
    @(posedge clk);
    #1;
    e = model(a, b, sg);
    e.cyc = cyc + ((b == 0) ? 0 : int'(N));
    exp_q.push_back(e);
    chk("busy_on_accept", 64'(busy), 64'd1);
    @(negedge clk);
    got = 0;
    for (int k = 0; k < int'(N) + 4; k++) begin
      if (done) begin
        got = 1;
        break;
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      dividend = N'($urandom);
      divisor = N'($urandom);
      @(negedge clk);
    end
    if (!got) chk("done_timeout", 64'(done), 64'd1);
    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  // Monitor: compare results on done, check one-cycle pulse and holding.
  logic [N-1:0] pq, pr;
  logic         pd, done_prev;
  initial begin
    pq = '0; pr = '0; pd = 1'b0; done_prev = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pq = '0; pr = '0; pd = 1'b0; done_prev = 1'b0;
      chk("done_in_reset", 64'(done), 64'd0);
    end else begin
      if (done) begin
        chk("done_width", 64'(done_prev), 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("quotient", 64'(quotient), 64'(e.q));
          chk("remainder", 64'(remainder), 64'(e.r));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          chk("latency", 64'(cyc), 64'(e.cyc));
          pq = e.q; pr = e.r; pd = e.dbz;
        end
      end else begin
        chk("hold", {quotient, remainder, div_by_zero}, {pq, pr, pd});
      end
      done_prev = done;
    end
  end

  initial begin
    logic [N-1:0] a, b;
    logic         sg;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
`ifdef DIVIDER_SIGNED_EN
    sg_drv = 1'b0;
`endif
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    issue(8'd100, 8'd7, 1'b0, 1'b0);
    issue(8'd255, 8'd0, 1'b0, 1'b0);
    issue(8'd5, 8'd9, 1'b0, 1'b0);
    issue(8'd200, 8'd10, 1'b0, 1'b1);

    // Abort 77/3 with reset during its 4th RUN cycle.
    start = 1'b1;
    dividend = 8'd77;
    divisor = 8'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_quotient", 64'(quotient), 64'd0);
    chk("abort_remainder", 64'(remainder), 64'd0);
    chk("abort_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    issue(8'd77, 8'd3, 1'b0, 1'b0);

`ifdef DIVIDER_SIGNED_EN
    issue(8'hF9, 8'd2, 1'b1, 1'b0);
    issue(8'h80, 8'hFF, 1'b1, 1'b0);
    issue(8'd7, 8'hFE, 1'b1, 1'b0);
    issue(8'hF9, 8'd0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 1000; i++) begin
      a = N'($urandom);
      if ($urandom_range(0, 15) == 0) b = '0;
      else if ($urandom_range(0, 1) == 1) b = N'($urandom_range(1, 15));
      else b = N'($urandom);
`ifdef DIVIDER_SIGNED_EN
      sg = 1'($urandom_range(0, 1));
`else
      sg = 1'b0;
`endif
      issue(a, b, sg, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("pending_results", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
